// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mc_pkg
// Brief    : Shared states, opcodes, mux encodings and per-state control table
//            for the multi-cycle RISC-V sequencing controller.
// Revision : 1.0
// ============================================================================
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ITYPE = 3'b011;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MDR    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  // The *_ready / *_zero fields are qualifiers applied to live inputs downstream.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_ready;
    logic       pc_write_zero;
    logic       ir_write_ready;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic ctrl_t ctrl_for_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.pc_write_ready = 1'b1;
        c.ir_write_ready = 1'b1;
        c.mem_read       = 1'b1;
        c.alu_src_a      = SRC_A_PC;
        c.alu_src_b      = SRC_B_FOUR;
        c.alu_op         = ALU_ADD;
        c.result_src     = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.result_src = RES_MDR;
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_RTYPE;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ITYPE;
      end
      S_ALU_WB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRC_A_RS1;
        c.alu_src_b     = SRC_B_RS2;
        c.alu_op        = ALU_SUB;
        c.result_src    = RES_ALUOUT;
        c.pc_write_zero = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRC_A_OLDPC;
        c.alu_src_b  = SRC_B_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mc_opcode_decoder
// Brief    : Maps a 7-bit opcode onto a one-hot instruction class.
// Revision : 1.0
// ============================================================================
module mc_opcode_decoder
  import riscv_mc_pkg::*;
(
  input  logic [6:0] op_i,
  output logic       is_r_o,
  output logic       is_i_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_jal_o,
  output logic       is_illegal_o
);

  always_comb begin
    is_r_o       = 1'b0;
    is_i_o       = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_branch_o  = 1'b0;
    is_jal_o     = 1'b0;
    is_illegal_o = 1'b0;
    case (op_i)
      OP_R:      is_r_o       = 1'b1;
      OP_I:      is_i_o       = 1'b1;
      OP_LOAD:   is_load_o    = 1'b1;
      OP_STORE:  is_store_o   = 1'b1;
      OP_BRANCH: is_branch_o  = 1'b1;
      OP_JAL:    is_jal_o     = 1'b1;
      default:   is_illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Brief    : Moore sequencer for the multi-cycle RISC-V core with ready-stalled
//            memory steps, sticky illegal flag and retired-instruction counter.
// Revision : 1.0
// ============================================================================
module multicycle_control_fsm
  import riscv_mc_pkg::*;
#(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               op_i,
  input  logic                     zero_i,
  input  logic                     mem_ready_i,
  output logic                     pc_write_o,
  output logic                     ir_write_o,
  output logic                     i_or_d_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic                     reg_write_o,
  output logic [1:0]               alu_src_a_o,
  output logic [1:0]               alu_src_b_o,
  output logic [2:0]               alu_op_o,
  output logic [1:0]               result_src_o,
  output logic [3:0]               state_o,
  output logic                     illegal_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  state_e                   state_q, state_d;
  ctrl_t                    ctrl_q, ctrl_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic                     illegal_q, illegal_d;
  logic                     retire;

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_illegal;

  mc_opcode_decoder u_dec (
    .op_i         (op_i),
    .is_r_o       (is_r),
    .is_i_o       (is_i),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_branch_o  (is_branch),
    .is_jal_o     (is_jal),
    .is_illegal_o (is_illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if (is_illegal)            state_d = S_TRAP;
        else if (is_r)             state_d = S_EXEC_R;
        else if (is_i)             state_d = S_EXEC_I;
        else if (is_load || is_store) state_d = S_MEM_ADDR;
        else if (is_branch)        state_d = S_BRANCH;
        else if (is_jal)           state_d = S_JAL;
        else                       state_d = S_TRAP;
      end
      S_MEM_ADDR: state_d = is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALU_WB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase

    retire = (state_d == S_FETCH) &&
             (state_q == S_MEM_WB || state_q == S_MEM_WR ||
              state_q == S_ALU_WB || state_q == S_BRANCH);
    instret_d = retire ? instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1} : instret_q;
    illegal_d = illegal_q | (state_d == S_TRAP);
    // Outputs are pre-decoded from the next state so they leave a flop.
    ctrl_d    = ctrl_for_state(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_for_state(S_FETCH);
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset gates the strobes directly so they fall with the reset edge itself.
  assign pc_write_o   = ~reset & (ctrl_q.pc_write |
                                  (ctrl_q.pc_write_ready & mem_ready_i) |
                                  (ctrl_q.pc_write_zero & zero_i));
  assign ir_write_o   = ~reset & ctrl_q.ir_write_ready & mem_ready_i;
  assign mem_read_o   = ~reset & ctrl_q.mem_read;
  assign mem_write_o  = ~reset & ctrl_q.mem_write;
  assign reg_write_o  = ~reset & ctrl_q.reg_write;
  assign i_or_d_o     = ctrl_q.i_or_d;
  assign alu_src_a_o  = ctrl_q.alu_src_a;
  assign alu_src_b_o  = ctrl_q.alu_src_b;
  assign alu_op_o     = ctrl_q.alu_op;
  assign result_src_o = ctrl_q.result_src;
  assign state_o      = state_q;
  assign illegal_o    = illegal_q;
  assign instret_o    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Brief    : Randomised bench comparing the controller against a trace model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control_fsm;

  localparam int IW = 4;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                         S_MEM_RD = 4'd3, S_MEM_WB = 4'd4, S_MEM_WR = 4'd5,
                         S_EXEC_R = 4'd6, S_EXEC_I = 4'd7, S_ALU_WB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

  localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, LW = 7'b0000011,
                         SW = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111;

  // Strobe bits in the packed observation word: pc, ir, mem_read, mem_write, reg_write.
  localparam logic [14:0] STROBES = 15'h6E00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] op_i = '0;
  logic zero_i = 1'b0;
  logic mem_ready_i = 1'b0;
  logic pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic illegal_o;
  logic [IW-1:0] instret_o;

  int checks = 0;
  int failures = 0;
  logic [IW-1:0] m_instret = '0;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;
  step_t trace[$];

  multicycle_control_fsm #(.INSTRET_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .result_src_o(result_src_o), .state_o(state_o), .illegal_o(illegal_o),
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [14:0] observed();
    return {pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o,
            alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o};
  endfunction

  // Output table per state, as listed in the controller description.
  function automatic logic [14:0] exp_out(input logic [3:0] st, input logic rdy, input logic z);
    logic pc, ir, iord, mr, mw, rw;
    logic [1:0] a, b, rs;
    logic [2:0] op;
    {pc, ir, iord, mr, mw, rw} = '0;
    a = 0; b = 0; rs = 0; op = 0;
    case (st)
      S_FETCH:    begin pc = rdy; ir = rdy; mr = 1; b = 1; rs = 2; end
      S_DECODE:   begin a = 2; b = 2; end
      S_MEM_ADDR: begin a = 1; b = 2; end
      S_MEM_RD:   begin iord = 1; mr = 1; end
      S_MEM_WB:   begin rs = 1; rw = 1; end
      S_MEM_WR:   begin iord = 1; mw = 1; end
      S_EXEC_R:   begin a = 1; op = 3'b010; end
      S_EXEC_I:   begin a = 1; b = 2; op = 3'b011; end
      S_ALU_WB:   begin rw = 1; end
      S_BRANCH:   begin a = 1; op = 3'b001; pc = z; end
      S_JAL:      begin a = 2; b = 1; pc = 1; end
      default:    ;
    endcase
    return {pc, ir, iord, mr, mw, rw, a, b, op, rs};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    step_t s;
    s.st = st;
    s.rdy = rdy;
    trace.push_back(s);
  endtask

  // Expected cycle-by-cycle state sequence of one instruction, with wait-states.
  task automatic build(input logic [6:0] op, input int fw, input int mw);
    trace.delete();
    for (int k = 0; k < fw; k++) push(S_FETCH, 1'b0);
    push(S_FETCH, 1'b1);
    push(S_DECODE, 1'($urandom));
    case (op)
      RTYPE: begin push(S_EXEC_R, 1'($urandom)); push(S_ALU_WB, 1'($urandom)); end
      ITYPE: begin push(S_EXEC_I, 1'($urandom)); push(S_ALU_WB, 1'($urandom)); end
      LW: begin
        push(S_MEM_ADDR, 1'($urandom));
        for (int k = 0; k < mw; k++) push(S_MEM_RD, 1'b0);
        push(S_MEM_RD, 1'b1);
        push(S_MEM_WB, 1'($urandom));
      end
      SW: begin
        push(S_MEM_ADDR, 1'($urandom));
        for (int k = 0; k < mw; k++) push(S_MEM_WR, 1'b0);
        push(S_MEM_WR, 1'b1);
      end
      BEQ: push(S_BRANCH, 1'($urandom));
      JAL: begin push(S_JAL, 1'($urandom)); push(S_ALU_WB, 1'($urandom)); end
      default: push(S_TRAP, 1'($urandom));
    endcase
  endtask

  task automatic play(input int n, input logic [6:0] op, input logic z);
    logic [14:0] e, o;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      op_i = (trace[k].st == S_FETCH) ? 7'($urandom) : op;
      mem_ready_i = trace[k].rdy;
      zero_i = (trace[k].st == S_BRANCH) ? z : 1'($urandom);
      #1;
      checks++;
      if (state_o !== trace[k].st) begin
        failures++;
        $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, k, state_o, trace[k].st);
      end
      e = exp_out(trace[k].st, trace[k].rdy, zero_i);
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL outputs op=%b cyc=%0d st=%0d got=%b exp=%b", op, k, trace[k].st, o, e);
      end
      checks++;
      if (illegal_o !== (trace[k].st == S_TRAP)) begin
        failures++;
        $display("FAIL illegal op=%b cyc=%0d got=%b", op, k, illegal_o);
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
    build(op, fw, mw);
    play(trace.size(), op, z);
    m_instret = m_instret + 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if (state_o !== S_FETCH || instret_o !== m_instret) begin
      failures++;
      $display("FAIL retire op=%b state=%0d instret=%0d exp_instret=%0d", op, state_o, instret_o, m_instret);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_ready_i = 1'b1;
    zero_i = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (state_o !== S_FETCH || illegal_o !== 1'b0 || instret_o !== '0) begin
      failures++;
      $display("FAIL reset_state state=%0d illegal=%b instret=%0d", state_o, illegal_o, instret_o);
    end
    checks++;
    if (observed() !== (exp_out(S_FETCH, 1'b1, 1'b1) & ~STROBES)) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", observed(), exp_out(S_FETCH, 1'b1, 1'b1) & ~STROBES);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready_i = 1'b0;
    m_instret = '0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    do_reset();
  endtask

  task automatic test_rtype();
    run_instr(RTYPE, 1'b0, 0, 0);
    run_instr(ITYPE, 1'b0, 1, 0);
  endtask

  task automatic test_load_wait();
    run_instr(LW, 1'b0, 0, 2);
    run_instr(SW, 1'b0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);
  endtask

  task automatic test_jal();
    run_instr(JAL, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[6];
    ops[0] = RTYPE; ops[1] = ITYPE; ops[2] = LW; ops[3] = SW; ops[4] = BEQ; ops[5] = JAL;
    // Enough instructions to wrap the narrow retired counter.
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 5)], 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  task automatic test_trap();
    build(7'b0000000, 0, 0);
    for (int k = 0; k < 20; k++) push(S_TRAP, 1'($urandom));
    play(trace.size(), 7'b0000000, 1'b1);
    do_reset();
    checks++;
    @(negedge clk);
    #1;
    if (state_o !== S_FETCH || illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL trap_clear state=%0d illegal=%b", state_o, illegal_o);
    end
  endtask

  task automatic test_reset_mid_write();
    run_instr(RTYPE, 1'b0, 0, 0);
    build(SW, 0, 4);
    play(5, SW, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_write_o !== 1'b0 || state_o !== S_FETCH) begin
      failures++;
      $display("FAIL async_reset mem_write=%b state=%0d", mem_write_o, state_o);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    m_instret = '0;
    checks++;
    if (state_o !== S_FETCH || instret_o !== m_instret || mem_write_o !== 1'b0) begin
      failures++;
      $display("FAIL after_reset state=%0d instret=%0d mem_write=%b", state_o, instret_o, mem_write_o);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jal();
    test_back_to_back();
    test_trap();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequencing controller for the multi-cycle variant of the RISC-V core. It replaces the single-cycle combinational control unit with a Moore state machine that time-shares one ALU and one unified instruction/data memory across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps. Memory accesses use a ready handshake so that wait-states stall the sequence. The block also keeps a retired-instruction counter for bring-up.

## Interface
Parameters:
- INSTRET_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_i  in  7  opcode, instruction[6:0], taken from the instruction register.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current access this cycle.
- pc_write_o  out  1  load PC from the result mux.
- ir_write_o  out  1  load the instruction register and the old-PC register.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- reg_write_o  out  1  register-file write enable.
- alu_src_a_o  out  2  ALU A select: 0 = PC, 1 = rs1, 2 = old PC.
- alu_src_b_o  out  2  ALU B select: 0 = rs2, 1 = constant 4, 2 = immediate.
- alu_op_o  out  3  ALU control: 000 = ADD, 001 = SUB, 010 = R-type funct, 011 = I-type funct.
- result_src_o  out  2  result mux select: 0 = ALUOut, 1 = MDR, 2 = live ALU result.
- state_o  out  4  current state, for debug.
- illegal_o  out  1  sticky flag: an unsupported opcode was seen.
- instret_o  out  INSTRET_WIDTH  count of retired instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, TRAP 11.
- Outputs not listed for a state are 0.
- FETCH:
  - i_or_d = 0, mem_read = 1, src_a = 0, src_b = 1, alu_op = ADD, result_src = 2.
  - ir_write = pc_write = mem_ready_i.
  - Stays in FETCH until mem_ready_i = 1, then goes to DECODE.
- DECODE: src_a = 2, src_b = 2, alu_op = ADD (branch/jump target goes to ALUOut). Next state by op_i:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → TRAP
- MEM_ADDR: src_a = 1, src_b = 2, ADD. Goes to MEM_RD if op_i = 0000011, otherwise to MEM_WR.
- MEM_RD: i_or_d = 1, mem_read = 1. Holds until mem_ready_i, then goes to MEM_WB.
- MEM_WB: result_src = 1, reg_write = 1, then FETCH.
- MEM_WR: i_or_d = 1, mem_write = 1. Holds until mem_ready_i, then goes to FETCH.
- EXEC_R: src_a = 1, src_b = 0, alu_op = 010, then ALU_WB.
- EXEC_I: src_a = 1, src_b = 2, alu_op = 011, then ALU_WB.
- ALU_WB: result_src = 0, reg_write = 1, then FETCH.
- BRANCH (BEQ only): src_a = 1, src_b = 0, SUB, result_src = 0, pc_write = zero_i, then FETCH.
- JAL: src_a = 2, src_b = 1, ADD, result_src = 0, pc_write = 1 (PC ← target), then ALU_WB (rd ← old PC + 4).
- TRAP: all strobes 0 and illegal_o = 1. Stays in TRAP until reset.
- instret_o increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, ALU_WB or BRANCH. It wraps modulo 2^INSTRET_WIDTH.

## Timing
- Reset (asynchronous): state = FETCH, instret_o = 0, illegal_o = 0.
- While reset is high, pc_write, ir_write, mem_read, mem_write and reg_write are forced to 0. The other outputs show the FETCH values.
- Strobes are Moore decodes of the state register. Exceptions: pc_write in FETCH and BRANCH, and ir_write in FETCH, are gated combinationally by mem_ready_i / zero_i in the same cycle.
- Latency with zero wait-states (mem_ready_i held at 1):
  - R-type, I-type, SW, JAL: 4 cycles.
  - LW: 5 cycles.
  - BEQ: 3 cycles.
- Each cycle with mem_ready_i = 0 in FETCH, MEM_RD or MEM_WR adds one cycle. During the stall, request and address outputs stay constant.
- mem_ready_i is ignored in every other state.
- Reset asserted mid-instruction aborts it. No write strobe may glitch high during or after the reset edge.

## Structure
- Shared package `riscv_mc_pkg` holds:
  - the state enum;
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL);
  - the alu_op, src_a, src_b and result_src encodings.
- One combinational sub-module, `mc_opcode_decoder`: maps op_i to a one-hot instruction class (r, i, load, store, branch, jal, illegal). The DECODE and MEM_ADDR transitions use it.
- Counter and state register stay in the top module.

## Test plan
- Reset then op_i = 0110011, ready = 1 → states 0, 1, 6, 8, 0. reg_write high only in ALU_WB. instret_o = 1 after 4 cycles.
- LW (0000011), ready low for 2 cycles in MEM_RD → states 0, 1, 2, 3, 3, 3, 4, 0. mem_read and i_or_d stable at 1 throughout MEM_RD. Total 7 cycles.
- BEQ with zero_i = 1 → pc_write = 1 in BRANCH with result_src = 0. Repeat with zero_i = 0 → pc_write = 0. Each case takes 3 cycles; instret increments in both.
- JAL → pc_write in FETCH and in JAL, reg_write in ALU_WB, alu_src_b = 1 in JAL. 4 cycles.
- op_i = 0000000 → TRAP at cycle 2, illegal_o = 1, no strobes for 20 cycles. Reset clears to FETCH with illegal_o = 0.
- Assert reset during MEM_WR with ready = 0 → mem_write drops immediately (asynchronous). After release: state FETCH, instret_o = 0.
